// File: rtl/vga_sync_rx.sv
// VGA sync receiver: samples h_sync/v_sync/blank_n, measures line and frame periods,
// locks to a stable timing and recovers active-area coordinates plus frame/line strobes.
module vga_sync_rx #(
    parameter int CNT_W       = 10,
    parameter bit SYNC_LOW    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             blank_n,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pos_x,
    output logic [CNT_W-1:0] pos_y,
    output logic             frame_start,
    output logic             line_start,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             locked,
    output logic             sync_err
);
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       MATCH_LOCK = 4'(LOCK_FRAMES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) return v;
        return v + CNT_ONE;
    endfunction

    state_t           state_q, state_d;
    logic             hs1_q, hs1_d, vs1_q, vs1_d, bl1_q, bl1_d;
    logic             hs2_q, hs2_d, vs2_q, vs2_d, bl2_q, bl2_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0] h_ref_q, h_ref_d, v_ref_q, v_ref_d;
    logic [3:0]       match_q, match_d;
    logic             first_line_q, first_line_d;
    logic             first_frame_q, first_frame_d;
    logic             line_bad_q, line_bad_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic             pix_valid_q, pix_valid_d;
    logic [CNT_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic             frame_start_q, frame_start_d;
    logic             line_start_q, line_start_d;
    logic             sync_err_q, sync_err_d;

    logic             hs_lead, vs_lead, bl_fall, ovf, frame_good;
    logic [CNT_W-1:0] line_per;

    always_comb begin
        // Stage s1 samples normalised inputs; stage s2 is its one-cycle delay for edges
        hs1_d = SYNC_LOW ? ~h_sync : h_sync;
        vs1_d = SYNC_LOW ? ~v_sync : v_sync;
        bl1_d = blank_n;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        bl2_d = bl1_q;

        hs_lead  = hs1_q & ~hs2_q;
        vs_lead  = vs1_q & ~vs2_q;
        bl_fall  = bl2_q & ~bl1_q;
        ovf      = (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
        line_per = hcnt_q + CNT_ONE;

        hcnt_d = hs_lead ? '0 : sat_inc(hcnt_q);
        vcnt_d = vcnt_q;
        if (vs_lead)      vcnt_d = '0;
        else if (hs_lead) vcnt_d = sat_inc(vcnt_q);

        // Coordinate outputs follow the input stream regardless of lock
        pix_valid_d   = bl1_q;
        pos_x_d       = (bl1_q && bl2_q) ? sat_inc(pos_x_q) : '0;
        pos_y_d       = pos_y_q;
        if (vs_lead)      pos_y_d = '0;
        else if (bl_fall) pos_y_d = sat_inc(pos_y_q);
        frame_start_d = vs_lead;
        line_start_d  = hs_lead;

        state_d       = state_q;
        h_ref_d       = h_ref_q;
        v_ref_d       = v_ref_q;
        match_d       = match_q;
        first_line_d  = first_line_q;
        first_frame_d = first_frame_q;
        line_bad_d    = line_bad_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        sync_err_d    = 1'b0;
        frame_good    = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (vs_lead) begin
                    state_d       = ST_MEASURE;
                    match_d       = '0;
                    first_frame_d = 1'b1;
                    first_line_d  = 1'b1;
                    line_bad_d    = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (ovf) begin
                    state_d = ST_SEARCH;
                end else if (vs_lead) begin
                    // First frame after SEARCH only establishes the vertical reference
                    frame_good    = !line_bad_q && (first_frame_q || (vcnt_q == v_ref_q));
                    v_ref_d       = vcnt_q;
                    first_frame_d = 1'b0;
                    first_line_d  = 1'b1;
                    line_bad_d    = 1'b0;
                    if (frame_good) begin
                        match_d = match_q + 4'd1;
                        if (match_q == MATCH_LOCK) begin
                            state_d   = ST_LOCKED;
                            h_total_d = h_ref_q;
                            v_total_d = vcnt_q;
                        end
                    end else begin
                        match_d = '0;
                    end
                end else if (hs_lead) begin
                    if (first_line_q) begin
                        h_ref_d      = line_per;
                        first_line_d = 1'b0;
                    end else if (line_per != h_ref_q) begin
                        line_bad_d = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (ovf || (hs_lead && (line_per != h_total_q)) ||
                    (vs_lead && (vcnt_q != v_total_q))) begin
                    state_d    = ST_SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEARCH;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            bl1_q         <= 1'b0;
            hs2_q         <= 1'b0;
            vs2_q         <= 1'b0;
            bl2_q         <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            h_ref_q       <= '0;
            v_ref_q       <= '0;
            match_q       <= '0;
            first_line_q  <= 1'b0;
            first_frame_q <= 1'b0;
            line_bad_q    <= 1'b0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            pix_valid_q   <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            bl1_q         <= bl1_d;
            hs2_q         <= hs2_d;
            vs2_q         <= vs2_d;
            bl2_q         <= bl2_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            h_ref_q       <= h_ref_d;
            v_ref_q       <= v_ref_d;
            match_q       <= match_d;
            first_line_q  <= first_line_d;
            first_frame_q <= first_frame_d;
            line_bad_q    <= line_bad_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            pix_valid_q   <= pix_valid_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = (state_q == ST_LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: an active-low and an active-high instance see the same timing
// (syncs mirrored); expected outputs are queued at drive time and compared two clocks later.
`timescale 1ns/1ps
module tb_vga_sync_rx;
    localparam int LOCK_FRAMES = 2;

    logic clk = 1'b0;
    logic rst;
    logic hs_lo, vs_lo, hs_hi, vs_hi, blank_n;
    logic       lo_pv, lo_fs, lo_ls, lo_lk, lo_se;
    logic [9:0] lo_px, lo_py, lo_ht, lo_vt;
    logic       hi_pv, hi_fs, hi_ls, hi_lk, hi_se;
    logic [9:0] hi_px, hi_py, hi_ht, hi_vt;

    always #5 clk = ~clk;

    vga_sync_rx #(.CNT_W(10), .SYNC_LOW(1'b1), .LOCK_FRAMES(LOCK_FRAMES)) dut_lo (
        .clk(clk), .rst(rst), .h_sync(hs_lo), .v_sync(vs_lo), .blank_n(blank_n),
        .pix_valid(lo_pv), .pos_x(lo_px), .pos_y(lo_py), .frame_start(lo_fs),
        .line_start(lo_ls), .h_total(lo_ht), .v_total(lo_vt), .locked(lo_lk),
        .sync_err(lo_se));

    vga_sync_rx #(.CNT_W(10), .SYNC_LOW(1'b0), .LOCK_FRAMES(LOCK_FRAMES)) dut_hi (
        .clk(clk), .rst(rst), .h_sync(hs_hi), .v_sync(vs_hi), .blank_n(blank_n),
        .pix_valid(hi_pv), .pos_x(hi_px), .pos_y(hi_py), .frame_start(hi_fs),
        .line_start(hi_ls), .h_total(hi_ht), .v_total(hi_vt), .locked(hi_lk),
        .sync_err(hi_se));

    typedef struct {
        logic pv;
        int   px;
        int   py;
        logic py_ok;
        logic fs;
        logic ls;
        logic chk;
        logic lk;
        logic se;
        int   ht;
        int   vt;
    } exp_t;

    exp_t sbq[$];
    int n_chk  = 0;
    int n_fail = 0;

    // Timing generator and reference model state
    int HT, VT, HA, VA, HS0, HSL, VS0, VSL;
    int gy;
    logic p_hs, p_vs;
    int leads, last_lead, drv_idx, exp_ht, exp_vt;
    logic coord_ok, chk_lk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cmp_one(input string p, input logic pv, input logic [9:0] px,
                           input logic [9:0] py, input logic fs, input logic ls,
                           input logic lk, input logic se, input logic [9:0] ht,
                           input logic [9:0] vt, input exp_t e);
        check_eq({p, "pix_valid"}, pv, e.pv);
        check_eq({p, "pos_x"}, px, e.px);
        if (e.py_ok) check_eq({p, "pos_y"}, py, e.py);
        check_eq({p, "frame_start"}, fs, e.fs);
        check_eq({p, "line_start"}, ls, e.ls);
        if (e.chk) begin
            check_eq({p, "locked"}, lk, e.lk);
            check_eq({p, "sync_err"}, se, e.se);
            check_eq({p, "h_total"}, ht, e.ht);
            check_eq({p, "v_total"}, vt, e.vt);
        end
    endtask

    task automatic compare(input exp_t e);
        cmp_one("lo_", lo_pv, lo_px, lo_py, lo_fs, lo_ls, lo_lk, lo_se, lo_ht, lo_vt, e);
        cmp_one("hi_", hi_pv, hi_px, hi_py, hi_fs, hi_ls, hi_lk, hi_se, hi_ht, hi_vt, e);
    endtask

    task automatic check_zero(input string p);
        exp_t z;
        z.pv = 0; z.px = 0; z.py = 0; z.py_ok = 1; z.fs = 0; z.ls = 0;
        z.chk = 1; z.lk = 0; z.se = 0; z.ht = 0; z.vt = 0;
        compare(z);
    endtask

    task automatic model_reset();
        p_hs = 0; p_vs = 0;
        leads = 0; last_lead = 0; exp_ht = 0; exp_vt = 0; coord_ok = 0;
    endtask

    // One clock: compare the output belonging to the drive two edges back, then drive.
    task automatic step(input logic hs, input logic vs, input logic bl, input int x, input int y);
        exp_t e;
        logic hl, vl;
        int per;
        @(posedge clk);
        #1;
        if (sbq.size() >= 2) compare(sbq.pop_front());
        hs_lo = ~hs; vs_lo = ~vs; hs_hi = hs; vs_hi = vs; blank_n = bl;
        drv_idx++;
        if (rst) begin
            p_hs = 0; p_vs = 0;
        end else begin
            hl = hs & ~p_hs;
            vl = vs & ~p_vs;
            e.se = 0;
            if (hl) begin
                per = drv_idx - last_lead;
                last_lead = drv_idx;
                if (chk_lk && leads > LOCK_FRAMES && per != exp_ht) begin
                    e.se = 1;
                    leads = 0;
                end
            end
            if (vl) begin
                coord_ok = 1;
                if (chk_lk && leads <= LOCK_FRAMES) begin
                    leads++;
                    if (leads == LOCK_FRAMES + 1) begin
                        exp_ht = HT;
                        exp_vt = VT;
                    end
                end
            end
            e.pv = bl; e.px = bl ? x : 0; e.py = y; e.py_ok = coord_ok && bl;
            e.fs = vl; e.ls = hl; e.chk = chk_lk; e.lk = (leads > LOCK_FRAMES);
            e.ht = exp_ht; e.vt = exp_vt;
            p_hs = hs; p_vs = vs;
            sbq.push_back(e);
        end
    endtask

    task automatic run_lines(input int nlines, input int short_l);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_l) ? HT - 1 : HT;
            for (int x = 0; x < len; x++)
                step(x >= HS0 && x < HS0 + HSL, gy >= VS0 && gy < VS0 + VSL,
                     x < HA && gy < VA, x, gy);
            gy = (gy + 1) % VT;
        end
    endtask

    initial begin
        int se_lo_n, se_hi_n, se_lo_at, se_hi_at;
        rst = 1'b1;
        hs_lo = 1; vs_lo = 1; hs_hi = 0; vs_hi = 0; blank_n = 0;
        drv_idx = 0; chk_lk = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_");

        // Larger timing: 100x40, active 64x30; lock at third vsync lead
        HT = 100; VT = 40; HA = 64; VA = 30; HS0 = 70; HSL = 10; VS0 = 32; VSL = 2;
        gy = 0;
        rst = 1'b0;
        run_lines(4 * VT + 5, -1);

        // Reset mid-frame while locked: outputs drop at once, then full reacquisition
        rst = 1'b1;
        #1;
        check_zero("midrst_");
        sbq.delete();
        model_reset();
        repeat (3) step(0, 0, 0, 0, 0);

        // Small timing: 20x10, active 12x6, restarting mid-frame
        HT = 20; VT = 10; HA = 12; VA = 6; HS0 = 14; HSL = 3; VS0 = 7; VSL = 1;
        gy = 2;
        rst = 1'b0;
        run_lines(4 * VT, -1);

        // One short line while locked, then relock
        run_lines(VT, 1);
        run_lines(3 * VT + 2, -1);

        // All syncs stop while locked: line counter saturates and lock is lost
        chk_lk = 0;
        se_lo_n = 0; se_hi_n = 0; se_lo_at = -1; se_hi_at = -1;
        for (int i = 0; i < 1100; i++) begin
            step(0, 0, 0, 0, 0);
            if (lo_se) begin se_lo_n++; se_lo_at = i; end
            if (hi_se) begin se_hi_n++; se_hi_at = i; end
        end
        check_eq("ovf_sync_err_pulses_lo", se_lo_n, 1);
        check_eq("ovf_sync_err_pulses_hi", se_hi_n, 1);
        check_eq("ovf_sync_err_window_lo", (se_lo_at >= 1000 && se_lo_at <= 1040), 1);
        check_eq("ovf_sync_err_window_hi", (se_hi_at >= 1000 && se_hi_at <= 1040), 1);
        check_eq("ovf_locked_lo", lo_lk, 0);
        check_eq("ovf_locked_hi", hi_lk, 0);

        // Timing resumes from the top of a frame and must relock
        gy = 0; leads = 0; coord_ok = 0; chk_lk = 1;
        run_lines(4 * VT, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
